// File: rtl/fetch_decode_stage.sv
// Sequential fetch from a 1-cycle imem into a small FIFO; the head is decoded under valid/ready.
// Define FETCH_PERF_CNT_EN to add the perf_fetched/perf_stall counter ports.
module fetch_decode_stage #(
  parameter int         ADDR_W     = 8,
  parameter int         FIFO_DEPTH = 2,
  parameter logic [3:0] HALT_OP    = 4'b1100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs1,
  output logic [3:0]        rs2,
  output logic [7:0]        imm8,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
`ifdef FETCH_PERF_CNT_EN
  output logic              halted,
  output logic [15:0]       perf_fetched,
  output logic [15:0]       perf_stall
`else
  output logic              halted
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_HALTED
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [15:0]       insn;
  } entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  entry_t            fifo_q [FIFO_DEPTH];
  entry_t            head;

  logic        run;
  logic        go;
  logic        ret;
  logic        ret_halt;
  logic        push;
  logic        pop;
  logic        issue;
  logic [CW:0] occ;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign run       = (state_q == S_RUN);
  assign go        = start & ((state_q == S_IDLE) | (state_q == S_HALTED));
  assign ret       = run & inflight_q;
  assign ret_halt  = ret & (imem_rdata[15:12] == HALT_OP);
  assign push      = ret & ~ret_halt;
  assign dec_valid = (count_q != '0);
  assign pop       = dec_valid & dec_ready;

  // Credit: entries held plus the word in flight, minus the one leaving now.
  assign occ = {1'b0, count_q}
             + {{CW{1'b0}}, inflight_q}
             - {{CW{1'b0}}, pop};

  assign issue = run & ~ret_halt & (occ < DEPTH_C);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (go) state_d = S_RUN;
      S_RUN:    if (ret_halt) state_d = S_DRAIN;
      S_DRAIN:  if (count_q == '0) state_d = S_HALTED;
      S_HALTED: if (go) state_d = S_RUN;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    inflight_d = issue;
    count_d    = count_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    if (go) begin
      pc_d       = start_addr;
      inflight_d = 1'b0;
      count_d    = '0;
      rptr_d     = '0;
      wptr_d     = '0;
    end else begin
      if (issue) pc_d = pc_q + ADDR_W'(1);
      if (push)  wptr_d = nxt(wptr_q);
      if (pop)   rptr_d = nxt(rptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      // The returning word belongs to the address issued last cycle.
      if (push) begin
        fifo_q[wptr_q].pc   <= pc_q - ADDR_W'(1);
        fifo_q[wptr_q].insn <= imem_rdata;
      end
    end
  end

  assign head      = fifo_q[rptr_q];
  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign opcode    = dec_valid ? head.insn[15:12] : '0;
  assign rd        = dec_valid ? head.insn[11:8]  : '0;
  assign rs1       = dec_valid ? head.insn[7:4]   : '0;
  assign rs2       = dec_valid ? head.insn[3:0]   : '0;
  assign imm8      = dec_valid ? head.insn[7:0]   : '0;
  assign pc_out    = dec_valid ? head.pc          : '0;
  assign busy      = (state_q == S_RUN) | (state_q == S_DRAIN);
  assign halted    = (state_q == S_HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetched_q, fetched_d;
  logic [15:0] stall_q, stall_d;

  always_comb begin
    fetched_d = fetched_q;
    stall_d   = stall_q;
    if (go) begin
      fetched_d = '0;
      stall_d   = '0;
    end else begin
      if (push && fetched_q != 16'hFFFF) fetched_d = fetched_q + 16'd1;
      if (dec_valid && !dec_ready && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: imem model, queue scoreboard, negedge monitor.
// Expected streams come from walking the memory image up to the first HALT word.
module tb_fetch_decode_stage;

  localparam logic [3:0] HALT_OP = 4'b1100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  start_addr = '0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b1;
  logic [3:0]  opcode, rd, rs1, rs2;
  logic [7:0]  imm8;
  logic [7:0]  pc_out;
  logic        busy, halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetched, perf_stall;
`endif

  fetch_decode_stage #(
    .ADDR_W(8),
    .FIFO_DEPTH(2),
    .HALT_OP(HALT_OP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .start_addr(start_addr),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .dec_valid(dec_valid),
    .dec_ready(dec_ready),
    .opcode(opcode),
    .rd(rd),
    .rs1(rs1),
    .rs2(rs2),
    .imm8(imm8),
    .pc_out(pc_out),
    .busy(busy),
`ifdef FETCH_PERF_CNT_EN
    .halted(halted),
    .perf_fetched(perf_fetched),
    .perf_stall(perf_stall)
`else
    .halted(halted)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem[imem_addr];
  end

  logic [23:0] exp_q [$];
  int          total = 0;
  int          bad = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_head;
  logic [31:0] got_w;
  logic [23:0] e_w;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else if (dec_valid) begin
      got_w = {pc_out, opcode, rd, rs1, rs2, imm8};
      if (stall_prev) chk("hold", 64'(got_w), 64'(prev_head));
      if (dec_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_out: got pc=%0h op=%0h want nothing", pc_out, opcode);
        end else begin
          e_w = exp_q.pop_front();
          chk("out", 64'(got_w),
              64'({e_w[23:16], e_w[15:12], e_w[11:8], e_w[7:4], e_w[3:0], e_w[7:0]}));
        end
        stall_prev = 1'b0;
      end else begin
        stall_prev = 1'b1;
        prev_head  = got_w;
      end
    end else begin
      stall_prev = 1'b0;
      chk("idle_zero", 64'({pc_out, opcode, rd, rs1, rs2, imm8}), 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input logic [7:0] a, input int halt_off);
    logic [15:0] w;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if (w[15:12] == HALT_OP) w[15:12] = 4'h0;
      mem[i] = w;
    end
    mem[8'(a + 8'(halt_off))] = {HALT_OP, 12'($urandom)};
  endtask

  task automatic load_expect(input logic [7:0] a);
    logic [7:0] p;
    p = a;
    for (int n = 0; n < 256; n++) begin
      if (mem[p][15:12] == HALT_OP) break;
      exp_q.push_back({p, mem[p]});
      p = p + 8'd1;
    end
  endtask

  task automatic do_start(input logic [7:0] a, input bit lat);
    load_expect(a);
    start_addr = a;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (lat) begin
      chk("req_c1", 64'(imem_req), 64'd1);
      chk("addr_c1", 64'(imem_addr), 64'(a));
      chk("busy_c1", 64'(busy), 64'd1);
      tick();
      chk("valid_c1", 64'(dec_valid), 64'd0);
      tick();
      chk("valid_c2", 64'(dec_valid), 64'd1);
      chk("pc_c2", 64'(pc_out), 64'(a));
    end
  endtask

  task automatic wait_halt(input bit rnd);
    for (int n = 0; n < 300 && !halted; n++) begin
      if (rnd) dec_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    if (!halted) begin
      total++;
      bad++;
      $display("FAIL halt_timeout: halted=0 want 1");
    end
    dec_ready = 1'b1;
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    chk("busy_halt", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    #12;
    chk("rst_valid", 64'(dec_valid), 64'd0);
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ADD, SUB, XOR, HALT at 0..3
    fill_mem(8'h00, 3);
    mem[0][15:12] = 4'h0;
    mem[1][15:12] = 4'h1;
    mem[2][15:12] = 4'h4;
    dec_ready = 1'b1;
    do_start(8'h00, 1'b1);
    chk("op_c2", 64'(opcode), 64'd0);
    tick();
    chk("op_c3", 64'(opcode), 64'd1);
    tick();
    chk("op_c4", 64'(opcode), 64'd4);
    tick();
    chk("halted_c5", 64'(halted), 64'd0);
    tick();
    chk("halted_c6", 64'(halted), 64'd1);
    chk("sb_stream", 64'(exp_q.size()), 64'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch_s", 64'(perf_fetched), 64'd3);
    chk("perf_stall_s", 64'(perf_stall), 64'd0);
`endif

    // Backpressure: ready low for cycles 2..7
    fill_mem(8'h20, 6);
    dec_ready = 1'b0;
    do_start(8'h20, 1'b0);
    tick();
    tick();
    tick();
    chk("bp_req", 64'(imem_req), 64'd0);
    chk("bp_valid", 64'(dec_valid), 64'd1);
    chk("bp_pc", 64'(pc_out), 64'h20);
    tick();
    tick();
    tick();
    tick();
    chk("bp_req7", 64'(imem_req), 64'd0);
    chk("bp_pc7", 64'(pc_out), 64'h20);
    chk("bp_op7", 64'(opcode), 64'(mem[8'h20][15:12]));
    dec_ready = 1'b1;
    wait_halt(1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch_bp", 64'(perf_fetched), 64'd6);
    chk("perf_stall_bp", 64'(perf_stall), 64'd5);
`endif

    // Address wrap FE, FF, then HALT at 00
    fill_mem(8'hFE, 2);
    mem[8'hFE][15:12] = 4'h2;
    mem[8'hFF][15:12] = 4'h3;
    do_start(8'hFE, 1'b1);
    wait_halt(1'b0);

    // Restart from HALTED
    fill_mem(8'h10, 5);
    do_start(8'h10, 1'b1);
    wait_halt(1'b1);

    // start while running is ignored
    fill_mem(8'h30, 14);
    dec_ready = 1'b1;
    do_start(8'h30, 1'b0);
    tick();
    tick();
    tick();
    start_addr = 8'h40;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_busy", 64'(busy), 64'd1);
    wait_halt(1'b1);

    for (int r = 0; r < 8; r++) begin
      a = 8'($urandom);
      fill_mem(a, $urandom_range(1, 15));
      do_start(a, 1'b0);
      wait_halt(1'b1);
    end

    // Async reset between edges in mid-stream
    fill_mem(8'h50, 20);
    do_start(8'h50, 1'b0);
    for (int i = 0; i < 5; i++) begin
      dec_ready = ($urandom_range(0, 1) != 0);
      tick();
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(dec_valid), 64'd0);
    chk("arst_req", 64'(imem_req), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    exp_q.delete();
`ifdef FETCH_PERF_CNT_EN
    chk("arst_pf", 64'(perf_fetched), 64'd0);
    chk("arst_ps", 64'(perf_stall), 64'd0);
`endif
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_halted", 64'(halted), 64'd0);
    chk("post_valid", 64'(dec_valid), 64'd0);
    chk("post_req", 64'(imem_req), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
